chimera_memisland_rst_seq: RTL and testbench



---
 rtl/chimera_memisland_rst_seq.sv | 87 ++++++++
 tb/tb_chimera_memisland_rst_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/chimera_memisland_rst_seq.sv
// chimera_memisland_rst_seq: staggered per-bank active-low reset release (power-on + req_valid/ready/mask re-reset; busy_o, done_o, rst_sync_no)
module chimera_memisland_rst_seq #(
  parameter int unsigned NumBanks      = 8,
  parameter int unsigned HoldCycles    = 4,
  parameter int unsigned StaggerCycles = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [NumBanks-1:0] req_mask_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [NumBanks-1:0] rst_sync_no
);
  localparam int unsigned PW   = NumBanks > 1 ? $clog2(NumBanks) : 1;
  localparam int unsigned CMax = HoldCycles > StaggerCycles ? HoldCycles : StaggerCycles;
  localparam int unsigned CW   = $clog2(CMax + 1);
  localparam logic [CW-1:0] HoldLast = CW'(HoldCycles - 1);
  localparam logic [CW-1:0] StagLast = CW'(StaggerCycles - 1);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_e;
  state_e              state_q;
  logic [NumBanks-1:0] act_q, rst_q, act_d;
  logic [PW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q, pend_q, fin;
  function automatic logic [PW-1:0] lowest(input logic [NumBanks-1:0] v);
    lowest = '0;
    for (int i = NumBanks - 1; i >= 0; i--) if (v[i]) lowest = PW'(i);
  endfunction
  always_comb begin
    fin   = state_q == RELEASE && act_q == '0;
    act_d = act_q & ~(NumBanks'(1) << ptr_q);
  end
  assign req_ready_o = state_q == IDLE || fin;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
  assign rst_sync_no = rst_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      act_q   <= '1;
      rst_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      done_q <= pend_q;
      pend_q <= 1'b0;
      case (state_q)
        HOLD: begin
          if (cnt_q == HoldLast) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            ptr_q   <= lowest(act_q);
          end else cnt_q <= cnt_q + CW'(1);
        end
        RELEASE: begin
          if (fin) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else begin
            rst_q <= rst_q | (NumBanks'(1) << ptr_q);
            act_q <= act_d;
            ptr_q <= lowest(act_d);
            cnt_q <= act_d != '0 ? StagLast : '0;
          end
        end
        default: ;
      endcase
      if (req_valid_i && req_ready_o) begin
        if (req_mask_i != '0) begin
          rst_q   <= rst_q & ~req_mask_i;
          act_q   <= req_mask_i;
          ptr_q   <= lowest(req_mask_i);
          state_q <= HoldCycles == 1 ? RELEASE : HOLD;
          cnt_q   <= HoldCycles == 1 ? '0 : CW'(1);
        end else begin
          state_q <= IDLE;
          pend_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_chimera_memisland_rst_seq.sv
// tb_chimera_memisland_rst_seq: scoreboard bench for the staggered bank reset sequencer
module tb_chimera_memisland_rst_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst1, v1, rdy1, busy1, done1;
  logic [3:0] m1, rs1;
  logic       rst2, v2, rdy2, busy2, done2;
  logic [0:0] m2, rs2;
  chimera_memisland_rst_seq #(.NumBanks(4), .HoldCycles(3), .StaggerCycles(2)) u1 (
    .clk_i(clk), .rst_i(rst1), .req_valid_i(v1), .req_ready_o(rdy1), .req_mask_i(m1),
    .busy_o(busy1), .done_o(done1), .rst_sync_no(rs1));
  chimera_memisland_rst_seq #(.NumBanks(1), .HoldCycles(1), .StaggerCycles(1)) u2 (
    .clk_i(clk), .rst_i(rst2), .req_valid_i(v2), .req_ready_o(rdy2), .req_mask_i(m2),
    .busy_o(busy2), .done_o(done2), .rst_sync_no(rs2));
  typedef struct {int c; logic [3:0] r; logic dn; logic b; logic rd; logic dc;} exp_t;
  exp_t q1[$], q2[$];
  int cyc = 0, total = 0, bad = 0, nd1 = 0, nd2 = 0, c0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int d, input int c, input logic [3:0] r, input logic dn, input logic b, input logic rd, input logic dc);
    exp_t e;
    e = '{c, r, dn, b, rd, dc};
    if (d == 1) q1.push_back(e); else q2.push_back(e);
  endtask
  task automatic chk(input int d, input exp_t e, input logic [3:0] r, input logic dn, input logic b, input logic rd);
    total++;
    if (e.c != cyc || r !== e.r || dn !== e.dn || b !== e.b || (!e.dc && rd !== e.rd)) begin
      bad++;
      $display("FAIL dut%0d cyc=%0d(exp %0d) rst got=%b exp=%b done got=%b exp=%b busy got=%b exp=%b ready got=%b exp=%b",
               d, cyc, e.c, r, e.r, dn, e.dn, b, e.b, rd, e.dc ? rd : e.rd);
    end
  endtask
  always @(negedge clk) begin
    if (done1 === 1'b1) nd1++;
    if (done2 === 1'b1) nd2++;
    while (q1.size() > 0 && q1[0].c <= cyc) chk(1, q1.pop_front(), rs1, done1, busy1, rdy1);
    while (q2.size() > 0 && q2[0].c <= cyc) chk(2, q2.pop_front(), {3'b000, rs2}, done2, busy2, rdy2);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic po(input int b, input int kmax);
    logic [3:0] r;
    for (int k = 0; k <= kmax; k++) begin
      for (int j = 0; j < 4; j++) r[j] = k >= 3 + 2 * j;
      push(1, b + k, r, k == 10, k < 10, k >= 10, k == 9);
    end
  endtask
  initial begin
    rst1 = 1'b1; rst2 = 1'b1; v1 = 1'b1; m1 = 4'b0001; v2 = 1'b0; m2 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      push(1, c, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
      push(2, c, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(); step();
    rst1 = 1'b0; rst2 = 1'b0; c0 = cyc + 1;
    po(c0, 9);
    push(1, c0 + 10, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1, c0 + 11, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, c0 + 12, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, c0 + 13, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1, c0 + 14, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, c0 + 15, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    push(2, c0 + 0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(2, c0 + 1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    push(2, c0 + 2, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
    push(2, c0 + 3, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (11) step();
    v1 = 1'b0;
    repeat (6) step();
    v1 = 1'b1; m1 = 4'b1010;
    step();
    c0 = cyc; v1 = 1'b0;
    for (int k = 0; k < 3; k++) push(1, c0 + k, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, c0 + 3, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, c0 + 4, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, c0 + 5, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1, c0 + 6, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, c0 + 7, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) step();
    v1 = 1'b1; m1 = 4'b0000;
    step();
    c0 = cyc; v1 = 1'b0;
    push(1, c0 + 0, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1, c0 + 1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, c0 + 2, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    v2 = 1'b1; m2 = 1'b1;
    step();
    c0 = cyc; v2 = 1'b0;
    push(2, c0 + 0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(2, c0 + 1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    push(2, c0 + 2, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
    push(2, c0 + 3, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    rst1 = 1'b1;
    step();
    push(1, cyc, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    rst1 = 1'b0; c0 = cyc + 1;
    po(c0, 6);
    repeat (7) step();
    rst1 = 1'b1;
    step();
    push(1, cyc, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    rst1 = 1'b0; c0 = cyc + 1;
    po(c0, 11);
    repeat (13) step();
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL queues_drained got=%0d/%0d exp=0/0", q1.size(), q2.size());
    end
    total++;
    if (nd1 != 5 || nd2 != 2) begin
      bad++;
      $display("FAIL done_pulses got=%0d/%0d exp=5/2", nd1, nd2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
